// File: rtl/sopc_data_subsys_if.sv
// CPU data-port bundle between the MIPS core and the data-side subsystem.
// The master drives the request; the slave returns read data in the same cycle.
interface sopc_data_subsys_if;
   logic        ce;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  sel;
   logic [31:0] data_i;
   logic [31:0] data_o;

   modport master (output ce, we, addr, sel, data_i, input data_o);
   modport slave  (input ce, we, addr, sel, data_i, output data_o);
endinterface

// File: rtl/sopc_data_subsys.sv
// Data-side subsystem: byte-writable RAM plus an I/O page holding a
// programmable timer, result registers and a sticky bus-error capture.
module sopc_data_subsys #(
   parameter int unsigned RAM_AW     = 10,
   parameter logic [31:0] DATA_BASE  = 32'h1001_0000,
   parameter logic [31:0] IO_BASE    = 32'hFFFF_0000,
   parameter int unsigned NUM_RESULT = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   sopc_data_subsys_if.slave         bus,
   output logic                      timer_int_o,
   output logic [31:0]               result,
   output logic [32*NUM_RESULT-1:0]  result_vec,
   output logic                      bus_err_o
);

   localparam int unsigned RAM_DEPTH  = 1 << RAM_AW;
   localparam int unsigned RES_BASE_W = 4;
   localparam logic [5:0]  W_CNT      = 6'h00;
   localparam logic [5:0]  W_CMP      = 6'h01;
   localparam logic [5:0]  W_CTRL     = 6'h02;
   localparam logic [5:0]  W_STAT     = 6'h03;
   localparam logic [5:0]  W_ERRADDR  = 6'h10;

   logic [31:0] r_mem [0:RAM_DEPTH-1];

   logic [31:0] r_cnt;
   logic [31:0] r_cmp;
   logic        r_en;
   logic        r_auto;
   logic        r_ie;
   logic        r_pending;
   logic [31:0] r_erraddr;
   logic [31:0] r_result [0:NUM_RESULT-1];

   logic                  w_ram_hit;
   logic                  w_io_hit;
   logic                  w_io_wr;
   logic                  w_full_sel;
   logic                  w_timer_reg;
   logic [5:0]            w_word;
   logic [NUM_RESULT-1:0] w_res_sel;
   logic                  w_cnt_wr;
   logic                  w_cmp_wr;
   logic                  w_ctrl_wr;
   logic                  w_stat_wr;
   logic                  w_io_legal_wr;
   logic                  w_err;
   logic                  w_match;
   logic [31:0]           w_wmask;
   logic [31:0]           w_io_rdata;

   // Address decode and write qualification
   always_comb begin
      w_word      = bus.addr[7:2];
      w_ram_hit   = bus.ce && (bus.addr[31:RAM_AW+2] == DATA_BASE[31:RAM_AW+2]);
      w_io_hit    = bus.ce && !w_ram_hit && (bus.addr[31:8] == IO_BASE[31:8]);
      w_io_wr     = w_io_hit && bus.we;
      w_full_sel  = (bus.sel == 4'hF);
      w_timer_reg = (w_word <= W_STAT);
      w_res_sel   = '0;
      for (int unsigned k = 0; k < NUM_RESULT; k++) begin
         w_res_sel[k] = (w_word == 6'(RES_BASE_W + k));
      end
      w_cnt_wr      = w_io_wr && w_full_sel && (w_word == W_CNT);
      w_cmp_wr      = w_io_wr && w_full_sel && (w_word == W_CMP);
      w_ctrl_wr     = w_io_wr && w_full_sel && (w_word == W_CTRL);
      w_stat_wr     = w_io_wr && w_full_sel && (w_word == W_STAT);
      w_io_legal_wr = (w_timer_reg && w_full_sel) || (|w_res_sel);
      w_err         = (bus.ce && !w_ram_hit && !w_io_hit) || (w_io_wr && !w_io_legal_wr);
      // A software CNT write in the same cycle suppresses the match entirely
      w_match       = r_en && (r_cnt == r_cmp) && !w_cnt_wr;
      w_wmask       = {{8{bus.sel[3]}}, {8{bus.sel[2]}}, {8{bus.sel[1]}}, {8{bus.sel[0]}}};
   end

   // Read path: combinational, zero when idle or unmapped
   always_comb begin
      w_io_rdata = '0;
      case (w_word)
         W_CNT:     w_io_rdata = r_cnt;
         W_CMP:     w_io_rdata = r_cmp;
         W_CTRL:    w_io_rdata = {29'd0, r_ie, r_auto, r_en};
         W_STAT:    w_io_rdata = {31'd0, r_pending};
         W_ERRADDR: w_io_rdata = r_erraddr;
         default: begin
            for (int unsigned k = 0; k < NUM_RESULT; k++) begin
               if (w_res_sel[k]) w_io_rdata = r_result[k];
            end
         end
      endcase
      bus.data_o = '0;
      if (w_ram_hit)     bus.data_o = r_mem[bus.addr[RAM_AW+1:2]];
      else if (w_io_hit) bus.data_o = w_io_rdata;
   end

   // RAM storage is intentionally left unreset
   always_ff @(posedge clk) begin
      if (w_ram_hit && bus.we) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (bus.sel[b]) r_mem[bus.addr[RAM_AW+1:2]][8*b +: 8] <= bus.data_i[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_cmp       <= 32'hFFFF_FFFF;
         r_en        <= 1'b0;
         r_auto      <= 1'b0;
         r_ie        <= 1'b0;
         r_pending   <= 1'b0;
         timer_int_o <= 1'b0;
         bus_err_o   <= 1'b0;
         r_erraddr   <= '0;
         for (int unsigned k = 0; k < NUM_RESULT; k++) r_result[k] <= '0;
      end else begin
         if (w_cnt_wr)     r_cnt <= bus.data_i;
         else if (w_match) r_cnt <= r_auto ? 32'd0 : r_cnt;
         else if (r_en)    r_cnt <= r_cnt + 32'd1;

         if (w_cmp_wr) r_cmp <= bus.data_i;

         if (w_ctrl_wr) begin
            r_en   <= bus.data_i[0];
            r_auto <= bus.data_i[1];
            r_ie   <= bus.data_i[2];
         end else if (w_match && !r_auto) begin
            r_en   <= 1'b0;
         end

         // New match outranks a same-cycle write-1-to-clear
         if (w_match)                         r_pending <= 1'b1;
         else if (w_stat_wr && bus.data_i[0]) r_pending <= 1'b0;

         timer_int_o <= r_pending && r_ie;

         for (int unsigned k = 0; k < NUM_RESULT; k++) begin
            if (w_io_wr && w_res_sel[k])
               r_result[k] <= (r_result[k] & ~w_wmask) | (bus.data_i & w_wmask);
         end

         if (w_err) begin
            bus_err_o <= 1'b1;
            if (!bus_err_o) r_erraddr <= bus.addr;
         end
      end
   end

   assign result = r_result[0];

   for (genvar g = 0; g < NUM_RESULT; g++) begin : g_res
      assign result_vec[32*g +: 32] = r_result[g];
   end

endmodule

// File: tb/tb_sopc_data_subsys.sv
// Directed self-checking bench for sopc_data_subsys: RAM byte writes, timer
// auto-reload and one-shot, result registers, bus errors and mid-count reset.
module tb_sopc_data_subsys;
   localparam logic [31:0] DB  = 32'h1001_0000;
   localparam logic [31:0] IOB = 32'hFFFF_0000;

   logic         clk = 1'b0;
   logic         rst;
   logic         timer_int_o;
   logic         bus_err_o;
   logic [31:0]  result;
   logic [127:0] result_vec;
   int           n_total = 0;
   int           n_bad   = 0;

   sopc_data_subsys_if bus ();

   sopc_data_subsys #(
      .RAM_AW(10), .DATA_BASE(DB), .IO_BASE(IOB), .NUM_RESULT(4)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .timer_int_o(timer_int_o),
      .result(result), .result_vec(result_vec), .bus_err_o(bus_err_o)
   );

   always #5 clk = ~clk;

   task automatic bus_idle();
      bus.ce = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.sel = '0; bus.data_i = '0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
      @(negedge clk);
      bus.ce = 1'b1; bus.we = 1'b1; bus.addr = a; bus.sel = s; bus.data_i = d;
      @(posedge clk); #1;
      bus_idle();
   endtask

   task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.ce = 1'b1; bus.we = 1'b0; bus.addr = a; bus.sel = 4'hF; bus.data_i = '0;
      #1 d = bus.data_o;
      @(posedge clk); #1;
      bus_idle();
   endtask

   task automatic test_reset();
      logic [31:0] d;
      bus_idle();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      n_total++; if (timer_int_o !== 1'b0) begin n_bad++; $display("FAIL reset_int got=%b want=0", timer_int_o); end
      n_total++; if (bus_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", bus_err_o); end
      n_total++; if (result_vec !== 128'd0) begin n_bad++; $display("FAIL reset_vec got=%h want=0", result_vec); end
      bus_rd(IOB + 32'h4, d);
      n_total++; if (d !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_cmp got=%h want=ffffffff", d); end
      bus_rd(IOB + 32'h0, d);
      n_total++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_cnt got=%h want=0", d); end
      @(negedge clk);
      bus.ce = 1'b0; bus.addr = IOB + 32'h4;
      #1;
      n_total++; if (bus.data_o !== 32'h0) begin n_bad++; $display("FAIL ce0_data got=%h want=0", bus.data_o); end
      bus_idle();
   endtask

   task automatic test_ram();
      logic [31:0] d;
      bus_wr(DB + 32'h8, 4'hF, 32'hAABB_CCDD);
      bus_wr(DB + 32'h8, 4'b0010, 32'h0000_1100);
      bus_rd(DB + 32'h8, d);
      n_total++; if (d !== 32'hAABB_11DD) begin n_bad++; $display("FAIL ram_bytewr got=%h want=aabb11dd", d); end
      bus_wr(DB + 32'hFFC, 4'hF, 32'hCAFE_F00D);
      bus_rd(DB + 32'hFFC, d);
      n_total++; if (d !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL ram_top got=%h want=cafef00d", d); end
      bus_rd(DB + 32'h8, d);
      n_total++; if (d !== 32'hAABB_11DD) begin n_bad++; $display("FAIL ram_noalias got=%h want=aabb11dd", d); end
   endtask

   task automatic test_timer_autoreload();
      logic [31:0] d;
      bus_wr(IOB + 32'h4, 4'hF, 32'd3);
      bus_wr(IOB + 32'h8, 4'hF, 32'd7);
      tick(4);
      n_total++; if (timer_int_o !== 1'b0) begin n_bad++; $display("FAIL ar_int_early got=%b want=0", timer_int_o); end
      tick(1);
      n_total++; if (timer_int_o !== 1'b1) begin n_bad++; $display("FAIL ar_int_set got=%b want=1", timer_int_o); end
      bus_wr(IOB + 32'hC, 4'hF, 32'd1);
      n_total++; if (timer_int_o !== 1'b1) begin n_bad++; $display("FAIL ar_int_lag got=%b want=1", timer_int_o); end
      bus_rd(IOB + 32'h0, d);
      n_total++; if (d !== 32'd2) begin n_bad++; $display("FAIL ar_reload got=%h want=2", d); end
      n_total++; if (timer_int_o !== 1'b0) begin n_bad++; $display("FAIL ar_int_clr got=%b want=0", timer_int_o); end
      bus_wr(IOB + 32'h8, 4'hF, 32'd0);
      bus_wr(IOB + 32'hC, 4'hF, 32'd1);
      bus_wr(IOB + 32'h0, 4'hF, 32'd0);
      tick(2);
      bus_rd(IOB + 32'hC, d);
      n_total++; if (d !== 32'd0) begin n_bad++; $display("FAIL ar_stat_idle got=%h want=0", d); end
      n_total++; if (timer_int_o !== 1'b0) begin n_bad++; $display("FAIL ar_int_idle got=%b want=0", timer_int_o); end
   endtask

   task automatic test_timer_oneshot();
      logic [31:0] d;
      bus_wr(IOB + 32'h4, 4'hF, 32'd2);
      bus_wr(IOB + 32'h8, 4'hF, 32'd5);
      tick(2);
      bus_wr(IOB + 32'hC, 4'hF, 32'd1);
      bus_rd(IOB + 32'hC, d);
      n_total++; if (d !== 32'd1) begin n_bad++; $display("FAIL os_w1c_race got=%h want=1", d); end
      bus_rd(IOB + 32'h8, d);
      n_total++; if (d !== 32'd4) begin n_bad++; $display("FAIL os_ctrl got=%h want=4", d); end
      bus_rd(IOB + 32'h0, d);
      n_total++; if (d !== 32'd2) begin n_bad++; $display("FAIL os_cnt got=%h want=2", d); end
      n_total++; if (timer_int_o !== 1'b1) begin n_bad++; $display("FAIL os_int got=%b want=1", timer_int_o); end
      tick(3);
      bus_rd(IOB + 32'h0, d);
      n_total++; if (d !== 32'd2) begin n_bad++; $display("FAIL os_cnt_hold got=%h want=2", d); end
      bus_wr(IOB + 32'hC, 4'hF, 32'd1);
      tick(2);
      bus_rd(IOB + 32'hC, d);
      n_total++; if (d !== 32'd0) begin n_bad++; $display("FAIL os_single got=%h want=0", d); end
      n_total++; if (timer_int_o !== 1'b0) begin n_bad++; $display("FAIL os_int_clr got=%b want=0", timer_int_o); end
   endtask

   task automatic test_results();
      logic [31:0] d;
      bus_wr(IOB + 32'h10, 4'hF, 32'h1234_5678);
      bus_wr(IOB + 32'h14, 4'b1100, 32'hFFFF_0000);
      n_total++; if (result !== 32'h1234_5678) begin n_bad++; $display("FAIL res0 got=%h want=12345678", result); end
      n_total++; if (result_vec[63:32] !== 32'hFFFF_0000) begin n_bad++; $display("FAIL res1 got=%h want=ffff0000", result_vec[63:32]); end
      bus_wr(IOB + 32'h14, 4'b0011, 32'h0000_ABCD);
      bus_rd(IOB + 32'h14, d);
      n_total++; if (d !== 32'hFFFF_ABCD) begin n_bad++; $display("FAIL res1_rd got=%h want=ffffabcd", d); end
      bus_wr(IOB + 32'h1C, 4'hF, 32'hDEAD_BEEF);
      n_total++; if (result_vec[127:96] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL res3 got=%h want=deadbeef", result_vec[127:96]); end
      bus_rd(IOB + 32'h30, d);
      n_total++; if (d !== 32'h0) begin n_bad++; $display("FAIL unimpl_rd got=%h want=0", d); end
      n_total++; if (bus_err_o !== 1'b0) begin n_bad++; $display("FAIL err_quiet got=%b want=0", bus_err_o); end
   endtask

   task automatic test_bus_error();
      logic [31:0] d;
      bus_rd(32'h0000_0040, d);
      n_total++; if (d !== 32'h0) begin n_bad++; $display("FAIL unmapped_data got=%h want=0", d); end
      n_total++; if (bus_err_o !== 1'b1) begin n_bad++; $display("FAIL err_set got=%b want=1", bus_err_o); end
      bus_rd(IOB + 32'h40, d);
      n_total++; if (d !== 32'h40) begin n_bad++; $display("FAIL erraddr got=%h want=40", d); end
      bus_wr(IOB + 32'h4, 4'b0011, 32'h0000_0000);
      bus_rd(IOB + 32'h4, d);
      n_total++; if (d !== 32'd2) begin n_bad++; $display("FAIL cmp_partial got=%h want=2", d); end
      bus_wr(IOB + 32'h20, 4'hF, 32'h55);
      bus_rd(IOB + 32'h20, d);
      n_total++; if (d !== 32'h0) begin n_bad++; $display("FAIL unimpl_wr got=%h want=0", d); end
      bus_rd(IOB + 32'h40, d);
      n_total++; if (d !== 32'h40) begin n_bad++; $display("FAIL erraddr_sticky got=%h want=40", d); end
   endtask

   task automatic test_reset_midcount();
      logic [31:0] d;
      bus_wr(IOB + 32'h4, 4'hF, 32'd100);
      bus_wr(IOB + 32'h0, 4'hF, 32'd0);
      bus_wr(IOB + 32'h8, 4'hF, 32'd5);
      tick(5);
      bus_rd(IOB + 32'h0, d);
      n_total++; if (d !== 32'd5) begin n_bad++; $display("FAIL mid_cnt got=%h want=5", d); end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_total++; if (bus_err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%b want=0", bus_err_o); end
      n_total++; if (result !== 32'h0) begin n_bad++; $display("FAIL rst_result got=%h want=0", result); end
      n_total++; if (result_vec !== 128'd0) begin n_bad++; $display("FAIL rst_vec got=%h want=0", result_vec); end
      bus_rd(IOB + 32'h8, d);
      n_total++; if (d !== 32'd0) begin n_bad++; $display("FAIL rst_ctrl got=%h want=0", d); end
      bus_rd(IOB + 32'h4, d);
      n_total++; if (d !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rst_cmp got=%h want=ffffffff", d); end
      bus_rd(IOB + 32'h40, d);
      n_total++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_erraddr got=%h want=0", d); end
      tick(110);
      bus_rd(IOB + 32'h0, d);
      n_total++; if (d !== 32'd0) begin n_bad++; $display("FAIL rst_cnt got=%h want=0", d); end
      n_total++; if (timer_int_o !== 1'b0) begin n_bad++; $display("FAIL rst_int got=%b want=0", timer_int_o); end
   endtask

   initial begin
      rst = 1'b1;
      bus_idle();
      test_reset();
      test_ram();
      test_timer_autoreload();
      test_timer_oneshot();
      test_results();
      test_bus_error();
      test_reset_midcount();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
